// File: rtl/onchip_mem_stream_master.sv
// Avalon-MM initiator for the single-port on-chip RAM. It either streams a block of
// RAM words out on a ready/valid source, or writes words taken from a ready/valid sink.
module onchip_mem_stream_master #(
    parameter int MEM_WORDS  = 40000,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_len,
    output logic              busy,
    output logic              done,
    output logic [31:0]       src_data,
    output logic              src_valid,
    input  logic              src_ready,
    input  logic [31:0]       snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata,
    output logic              clken
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
    localparam logic [PW:0]       DEPTH     = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [15:0]       remaining;
    logic              inflight;
    logic [31:0]       fifo [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       fifo_cnt;
    logic              rd_issue;
    logic              wr_issue;
    logic              push;
    logic              pop;

    // The in-flight return is counted against the buffer so it always has a slot.
    assign rd_issue  = (state == READ) && (remaining != '0) &&
                       ((fifo_cnt + {{PW{1'b0}}, inflight}) < DEPTH);
    assign snk_ready = (state == WRITE) && (remaining != '0);
    assign wr_issue  = snk_ready && snk_valid;
    assign push      = inflight;
    assign src_valid = (fifo_cnt != '0);
    assign src_data  = fifo[rd_ptr];
    assign pop       = src_valid && src_ready;
    assign next_addr = (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign chipselect = rd_issue || wr_issue;
    assign write      = wr_issue;
    assign address    = chipselect ? cur_addr : '0;
    assign writedata  = wr_issue ? snk_data : '0;
    assign byteenable = 4'hF;
    assign clken      = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
        end else begin
            inflight <= rd_issue;
            if (push) begin
                fifo[wr_ptr] <= readdata;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (rd_issue || wr_issue) begin
                cur_addr  <= next_addr;
                remaining <= remaining - 1'b1;
            end

            case (state)
                IDLE: if (cmd_valid) begin
                    cur_addr  <= cmd_addr;
                    remaining <= cmd_len;
                    if (cmd_len == '0)  state <= DONE;
                    else if (cmd_write) state <= WRITE;
                    else                state <= READ;
                end
                // Finish only once the last buffered word has left the source port.
                READ: if (remaining == '0 && !inflight &&
                          (fifo_cnt == '0 || (fifo_cnt == {{PW{1'b0}}, 1'b1} && pop)))
                    state <= DONE;
                WRITE: if (wr_issue && remaining == 16'd1) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_onchip_mem_stream_master.sv
// Bench for onchip_mem_stream_master: table of directed commands, a reset-abort
// sequence and randomized commands, checked against a shadow memory model.
module tb_onchip_mem_stream_master;
    localparam int MEM_WORDS  = 40000;
    localparam int ADDR_W     = 16;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_len;
    logic              busy, done;
    logic [31:0]       src_data;
    logic              src_valid, src_ready;
    logic [31:0]       snk_data;
    logic              snk_valid, snk_ready;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect, write;
    logic [31:0]       writedata;
    logic [31:0]       readdata = 32'h0;
    logic              clken;

    always #5 clk = ~clk;

    onchip_mem_stream_master #(
        .MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .busy(busy), .done(done),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .readdata(readdata), .clken(clken)
    );

    // RAM slave: one-cycle read latency, write sampled on the edge
    logic [31:0] ram     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    always @(posedge clk) begin
        if (chipselect) begin
            if (write) ram[address] = writedata;
            else       readdata <= ram[address];
        end
    end

    // Bus / stream monitor, sampled mid-cycle
    logic [15:0] bus_a [$];
    bit          bus_w [$];
    logic [31:0] bus_d [$];
    logic [31:0] src_q [$];
    int done_cnt = 0;
    int be_bad   = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (chipselect) begin
                bus_a.push_back(address);
                bus_w.push_back(write);
                bus_d.push_back(writedata);
                if (byteenable !== 4'hF) be_bad++;
            end
            if (src_valid && src_ready) src_q.push_back(src_data);
            if (done) done_cnt++;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_cmd(input bit wr, input int addr, input int len, input int mode,
                           input int exp_edges, input int exp_first, input int exp_n,
                           input int exp_last, input int chk_full);
        logic [31:0] wdata [64];
        int edges, first, wk, bound, outs, max_o, b0, s0, d0, e0;
        string tag;
        tag = $sformatf("%s@%0d/%0d", wr ? "wr" : "rd", addr, len);
        for (int i = 0; i < 64; i++)
            wdata[i] = (mode == 3) ? $urandom : 32'(i + 1) * 32'h11111111;
        b0 = bus_a.size(); s0 = src_q.size(); d0 = done_cnt; e0 = be_bad;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = 16'(addr); cmd_len = 16'(len);
        @(negedge clk);
        check({tag, " cmd_ready"}, int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        edges = 0; first = -1; wk = 0; outs = 0; max_o = 0; bound = len * 8 + 20;
        while (done !== 1'b1 && edges < bound) begin
            if (first < 0 && src_valid === 1'b1) first = edges;
            case (mode)
                0: begin src_ready = 1'b1; snk_valid = 1'b1; end
                1: begin src_ready = (edges % 2 == 0); snk_valid = (edges % 2 == 0); end
                2: begin src_ready = !(edges >= 3 && edges < 9); snk_valid = 1'b1; end
                default: begin
                    src_ready = ($urandom % 4 != 0);
                    snk_valid = ($urandom % 4 != 0);
                    // junk commands while busy must be ignored
                    cmd_valid = 1'($urandom % 2);
                    cmd_write = 1'($urandom % 2);
                    cmd_addr  = 16'($urandom % MEM_WORDS);
                    cmd_len   = 16'($urandom_range(1, 5));
                end
            endcase
            snk_data = (wk < len) ? wdata[wk] : 32'h0;
            @(negedge clk);
            if (snk_valid && snk_ready) wk++;
            if (chipselect && !write) outs++;
            if (src_valid && src_ready) outs--;
            if (outs > max_o) max_o = outs;
            @(posedge clk); #1;
            edges++;
        end
        cmd_valid = 1'b0; src_ready = 1'b0; snk_valid = 1'b0;
        check({tag, " done_seen"}, int'(done), 1);
        if (exp_edges >= 0) check({tag, " latency"}, edges, exp_edges);
        if (exp_first >= 0) check({tag, " first_valid"}, first, exp_first);
        if (chk_full != 0)  check({tag, " max_outstanding"}, max_o, FIFO_DEPTH);
        @(posedge clk); #1;
        check({tag, " idle_after"}, int'({done, busy, cmd_ready}), 1);
        check({tag, " done_pulses"}, done_cnt - d0, 1);
        check({tag, " bus_count"}, bus_a.size() - b0, exp_n);
        check({tag, " byteenable"}, be_bad - e0, 0);
        if (exp_n > 0 && bus_a.size() > b0) check({tag, " last_addr"}, int'(bus_a[$]), exp_last);
        for (int i = 0; i < len && b0 + i < bus_a.size(); i++) begin
            check({tag, " addr"}, int'(bus_a[b0 + i]), (addr + i) % MEM_WORDS);
            check({tag, " dir"}, int'(bus_w[b0 + i]), int'(wr));
            if (wr) check({tag, " wdata"}, int'(bus_d[b0 + i]), int'(wdata[i]));
        end
        if (!wr) begin
            check({tag, " src_count"}, src_q.size() - s0, len);
            for (int i = 0; i < len && s0 + i < src_q.size(); i++)
                check({tag, " src_data"}, int'(src_q[s0 + i]), int'(ref_mem[(addr + i) % MEM_WORDS]));
        end else begin
            for (int i = 0; i < len; i++) ref_mem[(addr + i) % MEM_WORDS] = wdata[i];
        end
    endtask

    typedef struct {
        bit wr; int addr; int len; int mode;
        int exp_edges; int exp_first; int exp_n; int exp_last; int full;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int s0, d0;
        vecs[0] = '{1'b0, 16, 8, 0, 10, 2, 8, 23, 0};
        vecs[1] = '{1'b1, 256, 4, 1, 7, -1, 4, 259, 0};
        vecs[2] = '{1'b0, 256, 4, 0, 6, 2, 4, 259, 0};
        vecs[3] = '{1'b0, 32, 10, 2, -1, 2, 10, 41, 1};
        vecs[4] = '{1'b0, 39998, 4, 0, 6, 2, 4, 1, 0};
        vecs[5] = '{1'b0, 5, 0, 0, 0, -1, 0, 0, 0};
        vecs[6] = '{1'b1, 64, 0, 0, 0, -1, 0, 0, 0};
        vecs[7] = '{1'b1, 39999, 2, 0, 2, -1, 2, 0, 0};
        vecs[8] = '{1'b0, 39999, 2, 0, 4, 2, 2, 0, 0};
        vecs[9] = '{1'b0, 5, 1, 0, 3, 2, 1, 5, 0};

        for (int i = 0; i < MEM_WORDS; i++) begin
            ram[i]     = 32'hA5000000 + 32'(i);
            ref_mem[i] = 32'hA5000000 + 32'(i);
        end
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        src_ready = 1'b0; snk_valid = 1'b0; snk_data = '0;

        @(negedge clk);
        check("rst cmd_ready", int'(cmd_ready), 1);
        check("rst busy_done", int'({busy, done}), 0);
        check("rst src_valid", int'(src_valid), 0);
        check("rst snk_ready", int'(snk_ready), 0);
        check("rst cs_write", int'({chipselect, write}), 0);
        check("rst address", int'(address), 0);
        check("rst writedata", int'(writedata), 0);
        check("rst src_data", int'(src_data), 0);
        check("rst be_clken", int'({byteenable, clken}), 31);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].exp_edges,
                    vecs[i].exp_first, vecs[i].exp_n, vecs[i].exp_last, vecs[i].full);

        // Abort a read with three words buffered and one return in flight
        s0 = src_q.size(); d0 = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0300; cmd_len = 16'd10;
        src_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort buffered", int'(src_valid), 1);
        check("abort head", int'(src_data), int'(ref_mem[16'h0300]));
        reset = 1'b1; #1;
        check("abort src_valid", int'(src_valid), 0);
        check("abort busy", int'({busy, cmd_ready}), 1);
        check("abort cs", int'(chipselect), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort fifo_empty", int'(src_valid), 0);
        check("abort idle", int'({busy, cmd_ready}), 1);
        check("abort no_done", done_cnt - d0, 0);
        check("abort no_pop", src_q.size() - s0, 0);
        run_cmd(1'b0, 16'h0310, 3, 0, 5, 2, 3, 16'h0312, 0);

        for (int k = 0; k < 25; k++) begin
            bit w;
            int a, l;
            w = 1'($urandom % 2);
            a = ($urandom % 2 != 0) ? MEM_WORDS - 1 - int'($urandom % 6) : int'($urandom % MEM_WORDS);
            l = int'($urandom % 13);
            run_cmd(w, a, l, 3, -1, (w || l == 0) ? -1 : 2, l, (a + l - 1) % MEM_WORDS, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
